// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipe_stage_reg                                                 |
// | Brief   : Pipeline-stage register with valid/ready handshake, flush,     |
// |           bubble-forced control and saturating stall counter.            |
// |           Optional skid entry enabled by macro PIPE_STAGE_SKID_EN.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int unsigned        CTRL_W   = 12,
   parameter int unsigned        DATA_W   = 56,
   parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{1'b0}},
   parameter logic [DATA_W-1:0]  DATA_RST = {DATA_W{1'b0}},
   parameter int unsigned        CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              out_valid_q, out_valid_d;
   logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              in_fire;
   logic              out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;

   // Ready depends only on registered skid occupancy, breaking the out_ready path.
   assign in_ready = ~skid_valid_q & ~flush;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_ctrl_d   = out_ctrl_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         out_ctrl_d   = CTRL_RST;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = CTRL_RST;
      end else if (out_fire) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_ctrl_d   = skid_ctrl_q;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = CTRL_RST;
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
         end else begin
            out_valid_d = 1'b0;
            out_ctrl_d  = CTRL_RST;
         end
      end else if (in_fire) begin
         if (out_valid_q) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
         end else begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= CTRL_RST;
         skid_data_q  <= DATA_RST;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
      end
   end
`else
   assign in_ready = ~flush & (out_ready | ~out_valid_q);

   always_comb begin
      out_valid_d = out_valid_q;
      out_ctrl_d  = out_ctrl_q;
      out_data_d  = out_data_q;
      if (flush) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = CTRL_RST;
      end else if (in_fire) begin
         out_valid_d = 1'b1;
         out_ctrl_d  = in_ctrl;
         out_data_d  = in_data;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = CTRL_RST;
      end
   end
`endif

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stat_clr) begin
         stall_cnt_d = '0;
      end else if (out_valid_q & ~out_ready & ~flush & ~(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= CTRL_RST;
         out_data_q  <= DATA_RST;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_ctrl_q  <= out_ctrl_d;
         out_data_q  <= out_data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_data  = out_data_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipe_stage_reg                                              |
// | Brief   : Self-checking bench for pipe_stage_reg (PIPE_STAGE_SKID_EN     |
// |           aware): vector table, directed corners, random vs queue model. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;

   localparam int CTRL_W = 12;
   localparam int DATA_W = 56;
   localparam int CNT_W  = 4;
   localparam logic [CTRL_W-1:0] CRST = 12'h040;
   localparam logic [DATA_W-1:0] DRST = 56'h000000_0000D0D0;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready, flush, out_valid, out_ready, stat_clr;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CNT_W-1:0]  stall_cnt;

   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CRST), .DATA_RST(DRST), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .stat_clr(stat_clr), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input bit ordy, input bit fl, input bit clr);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      stat_clr  = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input bit v, input logic [CTRL_W-1:0] c,
                          input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] n);
      chk({nm, "_valid"}, out_valid, v);
      chk({nm, "_ctrl"},  out_ctrl,  c);
      chk({nm, "_data"},  out_data,  d);
      chk({nm, "_cnt"},   stall_cnt, n);
   endtask

   // Reference model: an ordered queue of held entries with a fixed capacity.
   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;
   ent_t              mq[$];
   logic [DATA_W-1:0] m_last;
   int                m_cnt;

   function automatic bit m_ready(input bit ordy, input bit fl);
      if (fl) return 1'b0;
      if (SKID) return (mq.size() < 2);
      return (mq.size() == 0) || ordy;
   endfunction

   task automatic m_check(input string nm);
      chk({nm, "_valid"}, out_valid, (mq.size() > 0));
      chk({nm, "_ctrl"},  out_ctrl,  (mq.size() > 0) ? mq[0].c : CRST);
      chk({nm, "_data"},  out_data,  (mq.size() > 0) ? mq[0].d : m_last);
      chk({nm, "_cnt"},   stall_cnt, m_cnt[CNT_W-1:0]);
   endtask

   typedef struct {
      bit                v;
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
      bit                ordy, fl, clr;
      bit                e_rdy;
      bit                e_val;
      logic [CTRL_W-1:0] e_ctrl;
      logic [DATA_W-1:0] e_data;
      logic [CNT_W-1:0]  e_cnt;
   } vec_t;
   vec_t tbl[9];

   localparam logic [DATA_W-1:0] D1 = 56'h11111111111111;
   localparam logic [DATA_W-1:0] D2 = 56'h22222222222222;
   localparam logic [DATA_W-1:0] D3 = 56'h33333333333333;
   localparam logic [DATA_W-1:0] D4 = 56'h0123456789ABCD;
   localparam logic [DATA_W-1:0] DA = 56'hA5A5A5A5A5A5A5;
   localparam logic [DATA_W-1:0] DB = 56'hBBBBBBBBBBBBBB;
   localparam logic [DATA_W-1:0] DF = 56'hFEEDFACECAFE01;

   bit                r_v, r_o, r_f, r_cl, r_er;
   logic [CTRL_W-1:0] r_c;
   logic [DATA_W-1:0] r_d;
   ent_t              r_e;

   initial begin
      tbl[0] = '{1, 12'h00F, D1, 1, 0, 0, 1,    1, 12'h00F, D1, 4'd0};
      tbl[1] = '{1, 12'h00E, D2, 1, 0, 0, 1,    1, 12'h00E, D2, 4'd0};
      tbl[2] = '{1, 12'h00D, D3, 1, 0, 0, 1,    1, 12'h00D, D3, 4'd0};
      tbl[3] = '{0, 12'h000, '0, 1, 0, 0, 1,    0, CRST,    D3, 4'd0};
      tbl[4] = '{1, 12'hA5A, D4, 0, 0, 0, 1,    1, 12'hA5A, D4, 4'd0};
      tbl[5] = '{0, 12'h000, '0, 0, 0, 0, SKID, 1, 12'hA5A, D4, 4'd1};
      tbl[6] = '{0, 12'h000, '0, 0, 0, 1, SKID, 1, 12'hA5A, D4, 4'd0};
      tbl[7] = '{0, 12'h000, '0, 0, 0, 0, SKID, 1, 12'hA5A, D4, 4'd1};
      tbl[8] = '{0, 12'h000, '0, 1, 0, 0, 1,    0, CRST,    D4, 4'd1};

      reset = 1'b1;
      drive(0, '0, '0, 0, 0, 0);
      tick();
      chk_out("reset", 0, CRST, DRST, 4'd0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
         #1;
         chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].e_rdy);
         tick();
         chk_out($sformatf("tbl%0d", i), tbl[i].e_val, tbl[i].e_ctrl, tbl[i].e_data, tbl[i].e_cnt);
      end

      // Five-cycle stall holding entry A, then drain with no new input.
      drive(1, 12'h7C3, DA, 0, 0, 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, '0, '0, 0, 0, 0);
         #1;
         chk("stall_rdy", in_ready, SKID);
         tick();
         chk("stall_data", out_data, DA);
         chk("stall_valid", out_valid, 1'b1);
      end
      chk("stall_cnt5", stall_cnt, 4'd5);
      drive(0, '0, '0, 1, 0, 0);
      #1;
      chk("drain_rdy", in_ready, 1'b1);
      tick();
      chk_out("drain", 0, CRST, DA, 4'd5);

      // Flush against a stalled entry with a new entry offered.
      drive(1, 12'h0F1, DF, 0, 0, 1);
      tick();
      chk_out("fl_load", 1, 12'h0F1, DF, 4'd0);
      drive(1, 12'h123, DB, 0, 1, 0);
      #1;
      chk("fl_rdy", in_ready, 1'b0);
      tick();
      chk_out("fl_kill", 0, CRST, DF, 4'd0);
      drive(0, '0, '0, 1, 0, 0);
      tick();
      chk_out("fl_after", 0, CRST, DF, 4'd0);

      // Flush coincident with out_ready.
      drive(1, 12'h321, DA, 0, 0, 0);
      tick();
      drive(1, 12'h456, DB, 1, 1, 0);
      #1;
      chk("flr_rdy", in_ready, 1'b0);
      tick();
      chk_out("flr", 0, CRST, DA, 4'd0);

      // Saturation, then clear during the stall and resume counting.
      drive(1, 12'h00C, DB, 0, 0, 0);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(0, '0, '0, 0, 0, 0);
         tick();
      end
      chk("sat_cnt", stall_cnt, 4'hF);
      drive(0, '0, '0, 0, 0, 1);
      tick();
      chk("clr_cnt", stall_cnt, 4'd0);
      drive(0, '0, '0, 0, 0, 0);
      tick();
      chk("resume_cnt", stall_cnt, 4'd1);
      drive(0, '0, '0, 1, 0, 0);
      tick();
      chk("sat_drain", out_valid, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
      drive(1, 12'h0AA, DA, 0, 0, 0);
      #1;
      chk("skA_rdy", in_ready, 1'b1);
      tick();
      drive(1, 12'h0BB, DB, 0, 0, 0);
      #1;
      chk("skB_rdy", in_ready, 1'b1);
      tick();
      chk("skB_head", out_data, DA);
      drive(0, '0, '0, 0, 0, 0);
      #1;
      chk("skfull_rdy0", in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("skfull_rdy1", in_ready, 1'b0);
      tick();
      chk("skout_ctrl", out_ctrl, 12'h0BB);
      chk("skout_data", out_data, DB);
      chk("skout_valid", out_valid, 1'b1);
      tick();
      chk("skout_empty", out_valid, 1'b0);
`else
      drive(1, 12'h0AA, DA, 0, 0, 0);
      tick();
      drive(0, '0, '0, 0, 0, 0);
      #1;
      chk("comb_rdy0", in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("comb_rdy1", in_ready, 1'b1);
      tick();
      chk("comb_empty", out_valid, 1'b0);
`endif

      // Asynchronous reset mid-stream, checked before the next edge.
      drive(1, 12'h777, DF, 0, 0, 0);
      tick();
      drive(0, '0, '0, 0, 0, 0);
      tick();
      reset = 1'b1;
      #1;
      chk_out("areset", 0, CRST, DRST, 4'd0);
      tick();
      reset = 1'b0;
      mq.delete();
      m_last = DRST;
      m_cnt  = 0;

      for (int k = 0; k < 1500; k++) begin
         r_v  = ($urandom_range(0, 9) < 7);
         r_o  = ($urandom_range(0, 9) < 6);
         r_f  = ($urandom_range(0, 15) == 0);
         r_cl = ($urandom_range(0, 31) == 0);
         r_c  = CTRL_W'($urandom);
         r_d  = {24'($urandom), $urandom};
         drive(r_v, r_c, r_d, r_o, r_f, r_cl);
         #1;
         r_er = m_ready(r_o, r_f);
         chk("rnd_rdy", in_ready, r_er);
         tick();
         if (r_cl) m_cnt = 0;
         else if (mq.size() > 0 && !r_o && !r_f && m_cnt < 15) m_cnt++;
         if (r_f) begin
            mq.delete();
         end else begin
            if (mq.size() > 0 && r_o) void'(mq.pop_front());
            if (r_v && r_er) begin
               r_e.c = r_c;
               r_e.d = r_d;
               mq.push_back(r_e);
            end
         end
         if (mq.size() > 0) m_last = mq[0].d;
         m_check("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
